flicker_slew: RTL and testbench

FLICKER_SLEW -- requirements
Module: flicker_slew

---
 rtl/flicker_slew.sv | 111 +++++++++++
 tb/tb_flicker_slew.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/flicker_slew.sv
// Brightness slew limiter: ramps level toward a sampled target by STEP per tick, then dwells HOLD ticks.
// Optional FLICKER_SLEW_GAMMA_EN applies a registered square-law curve to the output level.
module flicker_slew #(
    parameter int STEP = 4,
    parameter int HOLD = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] target,
    output logic [7:0] level,
    output logic       busy,
    output logic       settled
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_RAMP_DOWN,
        ST_HOLD
    } state_t;

    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [3:0] HOLD4 = 4'(HOLD);

    state_t     state;
    logic [7:0] lvl;
    logic [7:0] tgt;
    logic [3:0] hold_cnt;

    // Ramp arithmetic at 9 bits so neither direction can wrap past the target.
    logic [8:0] up_sum;
    logic [8:0] down_floor;
    logic       up_reached;
    logic       down_reached;
    logic [7:0] up_next;
    logic [7:0] down_next;

    assign up_sum       = {1'b0, lvl} + STEP9;
    assign down_floor   = {1'b0, tgt} + STEP9;
    assign up_reached   = (up_sum >= {1'b0, tgt});
    assign down_reached = ({1'b0, lvl} <= down_floor);
    assign up_next      = up_reached   ? tgt : up_sum[7:0];
    assign down_next    = down_reached ? tgt : (lvl - STEP9[7:0]);

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            lvl      <= 8'd0;
            tgt      <= 8'd0;
            hold_cnt <= 4'd0;
            busy     <= 1'b0;
            settled  <= 1'b0;
        end else begin
            settled <= 1'b0;
            if (tick) begin
                unique case (state)
                    ST_IDLE: begin
                        tgt <= target;
                        if (target > lvl) begin
                            state <= ST_RAMP_UP;
                            busy  <= 1'b1;
                        end else if (target < lvl) begin
                            state <= ST_RAMP_DOWN;
                            busy  <= 1'b1;
                        end
                    end
                    ST_RAMP_UP, ST_RAMP_DOWN: begin
                        lvl <= (state == ST_RAMP_UP) ? up_next : down_next;
                        if ((state == ST_RAMP_UP) ? up_reached : down_reached) begin
                            if (HOLD4 == 4'd0) begin
                                state   <= ST_IDLE;
                                busy    <= 1'b0;
                                settled <= 1'b1;
                            end else begin
                                state    <= ST_HOLD;
                                hold_cnt <= HOLD4;
                            end
                        end
                    end
                    ST_HOLD: begin
                        hold_cnt <= hold_cnt - 4'd1;
                        if (hold_cnt == 4'd1) begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            settled <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef FLICKER_SLEW_GAMMA_EN
    logic [15:0] lvl_sq;
    assign lvl_sq = {8'd0, lvl} * {8'd0, lvl};

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 8'd0;
        end else begin
            level <= lvl_sq[15:8];
        end
    end
`else
    assign level = lvl;
`endif

endmodule

// File: tb/tb_flicker_slew.sv
// Self-checking bench for flicker_slew: a HOLD=3 and a HOLD=0 instance share stimulus and are
// compared every cycle against a plan-based reference model (honours FLICKER_SLEW_GAMMA_EN).
module tb_flicker_slew;

    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] target;
    logic [7:0] level_a, level_b;
    logic       busy_a, busy_b;
    logic       settled_a, settled_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    flicker_slew #(.STEP(STEP), .HOLD(3)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .target(target),
        .level(level_a), .busy(busy_a), .settled(settled_a)
    );

    flicker_slew #(.STEP(STEP), .HOLD(0)) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .target(target),
        .level(level_b), .busy(busy_b), .settled(settled_b)
    );

    // Reference model: on each accepted target, the full future trajectory (ramp values then
    // dwell repeats) is laid out in a plan; each later tick consumes one entry.
    int hold_p[2] = '{3, 0};
    int lvl_m[2];
    int gam_m[2];
    int busy_m[2];
    int settled_m[2];
    int plan[2][512];
    int plen[2];
    int pidx[2];

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                lvl_m[k]     = 0;
                gam_m[k]     = 0;
                busy_m[k]    = 0;
                settled_m[k] = 0;
                plen[k]      = 0;
                pidx[k]      = 0;
            end else begin
                gam_m[k]     = (lvl_m[k] * lvl_m[k]) >> 8;
                settled_m[k] = 0;
                if (tick) begin
                    if (pidx[k] == plen[k]) begin
                        int v;
                        int n;
                        int t;
                        v = lvl_m[k];
                        n = 0;
                        t = int'(target);
                        if (t != v) begin
                            while (v != t) begin
                                if (t > v) v = (v + STEP < t) ? v + STEP : t;
                                else       v = (v - STEP > t) ? v - STEP : t;
                                plan[k][n] = v;
                                n++;
                            end
                            for (int h = 0; h < hold_p[k]; h++) begin
                                plan[k][n] = t;
                                n++;
                            end
                            plen[k]   = n;
                            pidx[k]   = 0;
                            busy_m[k] = 1;
                        end
                    end else begin
                        lvl_m[k] = plan[k][pidx[k]];
                        pidx[k]++;
                        if (pidx[k] == plen[k]) begin
                            busy_m[k]    = 0;
                            settled_m[k] = 1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic int exp_level(input int k);
`ifdef FLICKER_SLEW_GAMMA_EN
        return gam_m[k];
`else
        return lvl_m[k];
`endif
    endfunction

    task automatic compare_all();
        check("level_a",   int'(level_a),   exp_level(0));
        check("busy_a",    int'(busy_a),    busy_m[0]);
        check("settled_a", int'(settled_a), settled_m[0]);
        check("level_b",   int'(level_b),   exp_level(1));
        check("busy_b",    int'(busy_b),    busy_m[1]);
        check("settled_b", int'(settled_b), settled_m[1]);
    endtask

    task automatic step(input logic r, input logic t, input logic [7:0] tg);
        reset  = r;
        tick   = t;
        target = tg;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic gap(input int n, input logic [7:0] tg);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, tg);
    endtask

    // Literal level expectations hold only for the ungated output path.
    task automatic check_level_lit(input string tag, input int exp);
`ifndef FLICKER_SLEW_GAMMA_EN
        check(tag, int'(level_a), exp);
`endif
    endtask

    initial begin
        reset  = 1'b1;
        tick   = 1'b1;
        target = 8'd200;

        // Reset held two cycles with tick and a live target.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 8'd200);
            check("rst_level", int'(level_a), 0);
            check("rst_busy", int'(busy_a), 0);
            check("rst_settled", int'(settled_a), 0);
        end
        step(1'b0, 1'b0, 8'd200);
        check("rel_level", int'(level_a), 0);
        check("rel_busy", int'(busy_a), 0);

        // Ramp up 0 -> 10 with a tick every 4th cycle.
        step(1'b0, 1'b1, 8'd10); check("up_latch_busy", int'(busy_a), 1); gap(3, 8'd10);
        step(1'b0, 1'b1, 8'd10); check_level_lit("up_l4", 4);  gap(3, 8'd10);
        step(1'b0, 1'b1, 8'd10); check_level_lit("up_l8", 8);  gap(3, 8'd10);
        step(1'b0, 1'b1, 8'd10); check_level_lit("up_l10", 10);
        check("up_busy_hold", int'(busy_a), 1);
        check("h0_settled", int'(settled_b), 1);
        check("h0_busy", int'(busy_b), 0);
        gap(3, 8'd10);
        step(1'b0, 1'b1, 8'd10); gap(3, 8'd10);
        step(1'b0, 1'b1, 8'd10); check("hold2_settled", int'(settled_a), 0); gap(3, 8'd10);
        step(1'b0, 1'b1, 8'd10);
        check("up_settled", int'(settled_a), 1);
        check("up_done_busy", int'(busy_a), 0);
        gap(1, 8'd10);
        check("settled_pulse", int'(settled_a), 0);
        gap(2, 8'd10);

        // Ramp down 10 -> 0, clamped at the floor.
        step(1'b0, 1'b1, 8'd0); gap(3, 8'd0);
        step(1'b0, 1'b1, 8'd0); check_level_lit("dn_l6", 6); gap(3, 8'd0);
        step(1'b0, 1'b1, 8'd0); check_level_lit("dn_l2", 2); gap(3, 8'd0);
        step(1'b0, 1'b1, 8'd0); check_level_lit("dn_l0", 0); gap(3, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'd0); gap(3, 8'd0);
        end

        // Retarget mid-ramp is ignored until the next IDLE tick.
        step(1'b0, 1'b1, 8'd10); gap(3, 8'd10);
        step(1'b0, 1'b1, 8'd10); gap(3, 8'd200);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'd200); gap(3, 8'd200);
        end
        check_level_lit("mid_stop10", 10);
        check("mid_idle", int'(busy_a), 0);
        step(1'b0, 1'b1, 8'd200);
        check("mid_take200", int'(busy_a), 1);
        step(1'b0, 1'b1, 8'd200);
        check_level_lit("mid_l14", 14);

        // Long tick starvation mid-ramp.
        gap(50, 8'd37);
        check_level_lit("stall_level", 14);
        check("stall_busy", int'(busy_a), 1);

        // Randomised traffic with boundary-biased targets and rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       t;
            logic [7:0] tg;
            r = ($urandom_range(0, 299) == 0);
            t = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                0:       tg = 8'd0;
                1:       tg = 8'd255;
                2:       tg = 8'd128;
                default: tg = 8'($urandom_range(0, 255));
            endcase
            step(r, t, tg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
